// File: rtl/controlador_embalagem_if.sv
// Operator panel, conveyor sensor, belt motor and box handler signals of the packaging controller.
interface controlador_embalagem_if;
    localparam int unsigned CONTAGEM_W = 4;
    localparam int unsigned CAIXAS_W   = 8;

    logic                  habilita;
    logic                  sensor_item;
    logic                  troca_ack;
    logic                  esteira;
    logic                  troca_req;
    logic [CONTAGEM_W-1:0] contagem;
    logic                  caixa_cheia;
    logic                  perdido;
    logic                  erro;
    logic [CAIXAS_W-1:0]   caixas;

    // Plant side: panel, sensor and handler drive inputs, observe actuators/status.
    modport master (
        output habilita, sensor_item, troca_ack,
        input  esteira, troca_req, contagem, caixa_cheia, perdido, erro, caixas
    );

    // Controller side.
    modport slave (
        input  habilita, sensor_item, troca_ack,
        output esteira, troca_req, contagem, caixa_cheia, perdido, erro, caixas
    );
endinterface

// File: rtl/controlador_embalagem.sv
// Packaging controller: counts items into boxes of 12, stops the belt, handshakes
// a box change with the handler and restarts. Optional completed-box counter is
// built when CONTA_CAIXAS_EN is defined; otherwise caixas reads 0.
module controlador_embalagem #(
    parameter int unsigned PARADA_CICLOS  = 4,
    parameter int unsigned TIMEOUT_CICLOS = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    controlador_embalagem_if.slave bus
);
    localparam int unsigned CONTAGEM_W = 4;
    localparam int unsigned CAIXAS_W   = 8;
    localparam int unsigned TMR_W      = 16;

    localparam logic [CONTAGEM_W-1:0] CONTAGEM_MAX = CONTAGEM_W'(12);
    localparam logic [TMR_W-1:0]      PARADA_FIM   = TMR_W'(PARADA_CICLOS - 1);
    localparam logic [TMR_W-1:0]      TIMEOUT_FIM  = TMR_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONTANDO,
        PARADA,
        TROCA,
        LIBERA,
        ERRO
    } estado_t;

    estado_t               estado;
    logic [TMR_W-1:0]      timer;
    logic                  sinc_1;
    logic                  sinc_2;
    logic                  sinc_3;
    logic                  item_pulso;
    logic                  esteira_q;
    logic                  troca_req_q;
    logic [CONTAGEM_W-1:0] contagem_q;
    logic                  caixa_cheia_q;
    logic                  perdido_q;
    logic                  erro_q;
    logic [CAIXAS_W-1:0]   caixas_q;

    // Two-stage synchronizer for the raw sensor plus a delay stage for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_1 <= 1'b0;
            sinc_2 <= 1'b0;
            sinc_3 <= 1'b0;
        end else begin
            sinc_1 <= bus.sensor_item;
            sinc_2 <= sinc_1;
            sinc_3 <= sinc_2;
        end
    end

    assign item_pulso = sinc_2 & ~sinc_3;

    // Controller FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= IDLE;
            timer         <= '0;
            esteira_q     <= 1'b0;
            troca_req_q   <= 1'b0;
            contagem_q    <= '0;
            caixa_cheia_q <= 1'b0;
            perdido_q     <= 1'b0;
            erro_q        <= 1'b0;
`ifdef CONTA_CAIXAS_EN
            caixas_q      <= '0;
`endif
        end else begin
            caixa_cheia_q <= 1'b0;
            perdido_q     <= 1'b0;

            // Items arriving while the belt is not in counting mode are reported, never counted.
            if (item_pulso && (estado != CONTANDO)) begin
                perdido_q <= 1'b1;
            end

            case (estado)
                IDLE: begin
                    esteira_q <= 1'b0;
                    if (bus.habilita) begin
                        estado    <= CONTANDO;
                        esteira_q <= 1'b1;
                    end
                end

                CONTANDO: begin
                    if (item_pulso && (contagem_q < CONTAGEM_MAX)) begin
                        contagem_q <= contagem_q + CONTAGEM_W'(1);
                    end
                    // Completing the box takes priority over a simultaneous disable.
                    if (item_pulso && (contagem_q == CONTAGEM_MAX - CONTAGEM_W'(1))) begin
                        estado    <= PARADA;
                        esteira_q <= 1'b0;
                        timer     <= '0;
                    end else if (!bus.habilita) begin
                        estado    <= IDLE;
                        esteira_q <= 1'b0;
                    end
                end

                PARADA: begin
                    esteira_q <= 1'b0;
                    if (timer == PARADA_FIM) begin
                        estado      <= TROCA;
                        troca_req_q <= 1'b1;
                        timer       <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                TROCA: begin
                    // Acknowledge wins over a timeout expiring on the same cycle.
                    if (bus.troca_ack) begin
                        estado        <= LIBERA;
                        troca_req_q   <= 1'b0;
                        contagem_q    <= '0;
                        caixa_cheia_q <= 1'b1;
`ifdef CONTA_CAIXAS_EN
                        caixas_q      <= caixas_q + CAIXAS_W'(1);
`endif
                    end else if (timer == TIMEOUT_FIM) begin
                        estado      <= ERRO;
                        troca_req_q <= 1'b0;
                        erro_q      <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                LIBERA: begin
                    if (!bus.troca_ack) begin
                        if (bus.habilita) begin
                            estado    <= CONTANDO;
                            esteira_q <= 1'b1;
                        end else begin
                            estado <= IDLE;
                        end
                    end
                end

                ERRO: begin
                    esteira_q   <= 1'b0;
                    troca_req_q <= 1'b0;
                    erro_q      <= 1'b1;
                end

                default: begin
                    estado      <= IDLE;
                    esteira_q   <= 1'b0;
                    troca_req_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef CONTA_CAIXAS_EN
    assign caixas_q = '0;
`endif

    assign bus.esteira     = esteira_q;
    assign bus.troca_req   = troca_req_q;
    assign bus.contagem    = contagem_q;
    assign bus.caixa_cheia = caixa_cheia_q;
    assign bus.perdido     = perdido_q;
    assign bus.erro        = erro_q;
    assign bus.caixas      = caixas_q;

endmodule

// File: tb/tb_controlador_embalagem.sv
// Directed self-checking bench for controlador_embalagem (default parameters).
module tb_controlador_embalagem;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    controlador_embalagem_if bus ();

    controlador_embalagem #(
        .PARADA_CICLOS  (4),
        .TIMEOUT_CICLOS (1000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected box counter value after n completed boxes in this build.
    function automatic logic [7:0] exp_caixas(input int n);
`ifdef CONTA_CAIXAS_EN
        return 8'(n);
`else
        return 8'd0 + 8'(n * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sensor high for two periods; returns right after the edge that updates contagem.
    task automatic pulse_item();
        bus.sensor_item = 1'b1;
        tick();
        tick();
        bus.sensor_item = 1'b0;
        tick();
    endtask

    // Runs the ack handshake from TROCA back to CONTANDO.
    task automatic do_ack();
        bus.troca_ack = 1'b1;
        tick();
        bus.troca_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++;
        if ({bus.esteira, bus.troca_req, bus.contagem, bus.caixa_cheia, bus.perdido, bus.erro, bus.caixas} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs: got esteira=%b req=%b cont=%0d cheia=%b perd=%b erro=%b caixas=%0d want all 0",
                     bus.esteira, bus.troca_req, bus.contagem, bus.caixa_cheia, bus.perdido, bus.erro, bus.caixas);
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (bus.esteira !== 1'b0 || bus.contagem !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_reset: esteira=%b cont=%0d want 0 0", bus.esteira, bus.contagem);
        end
    endtask

    task automatic test_contagem();
        bus.habilita = 1'b1;
        tick();
        total++;
        if (bus.esteira !== 1'b1) begin
            bad++;
            $display("FAIL belt_start: esteira=%b want 1", bus.esteira);
        end
        for (int i = 1; i <= 12; i++) begin
            pulse_item();
            total++;
            if (bus.contagem !== 4'(i)) begin
                bad++;
                $display("FAIL count_step: contagem=%0d want %0d", bus.contagem, i);
            end
            total++;
            if (bus.esteira !== (i < 12)) begin
                bad++;
                $display("FAIL belt_at_count: esteira=%b want %b at count %0d", bus.esteira, (i < 12), i);
            end
        end
    endtask

    // Pulse arriving right as PARADA begins: perdido at the 3rd edge, troca_req at the 4th.
    task automatic test_perdido();
        pulse_item();
        total++;
        if (bus.perdido !== 1'b1 || bus.contagem !== 4'd12 || bus.troca_req !== 1'b0) begin
            bad++;
            $display("FAIL perdido_parada: perd=%b cont=%0d req=%b want 1 12 0", bus.perdido, bus.contagem, bus.troca_req);
        end
        tick();
        total++;
        if (bus.perdido !== 1'b0 || bus.troca_req !== 1'b1) begin
            bad++;
            $display("FAIL req_after_parada: perd=%b req=%b want 0 1", bus.perdido, bus.troca_req);
        end
    endtask

    task automatic test_troca();
        bus.troca_ack = 1'b1;
        tick();
        total++;
        if (bus.troca_req !== 1'b0 || bus.contagem !== 4'd0 || bus.caixa_cheia !== 1'b1 || bus.caixas !== exp_caixas(1)) begin
            bad++;
            $display("FAIL ack_response: req=%b cont=%0d cheia=%b caixas=%0d want 0 0 1 %0d",
                     bus.troca_req, bus.contagem, bus.caixa_cheia, bus.caixas, exp_caixas(1));
        end
        bus.troca_ack = 1'b0;
        tick();
        total++;
        if (bus.esteira !== 1'b1 || bus.caixa_cheia !== 1'b0) begin
            bad++;
            $display("FAIL belt_restart: esteira=%b cheia=%b want 1 0", bus.esteira, bus.caixa_cheia);
        end
    endtask

    task automatic test_desabilita();
        for (int i = 0; i < 5; i++) pulse_item();
        bus.habilita = 1'b0;
        tick();
        total++;
        if (bus.esteira !== 1'b0 || bus.contagem !== 4'd5) begin
            bad++;
            $display("FAIL disable_hold: esteira=%b cont=%0d want 0 5", bus.esteira, bus.contagem);
        end
        pulse_item();
        total++;
        if (bus.perdido !== 1'b1 || bus.contagem !== 4'd5) begin
            bad++;
            $display("FAIL perdido_idle: perd=%b cont=%0d want 1 5", bus.perdido, bus.contagem);
        end
        bus.habilita = 1'b1;
        tick();
        total++;
        if (bus.esteira !== 1'b1) begin
            bad++;
            $display("FAIL reenable: esteira=%b want 1", bus.esteira);
        end
        for (int i = 0; i < 7; i++) pulse_item();
        total++;
        if (bus.contagem !== 4'd12 || bus.esteira !== 1'b0) begin
            bad++;
            $display("FAIL resume_full: cont=%0d esteira=%b want 12 0", bus.contagem, bus.esteira);
        end
        ticks(3);
        total++;
        if (bus.troca_req !== 1'b0) begin
            bad++;
            $display("FAIL req_early: req=%b want 0", bus.troca_req);
        end
        tick();
        total++;
        if (bus.troca_req !== 1'b1) begin
            bad++;
            $display("FAIL req_on_time: req=%b want 1", bus.troca_req);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) pulse_item();
        ticks(4);
        do_ack();
        total++;
        if (bus.caixas !== exp_caixas(3) || bus.esteira !== 1'b1 || bus.contagem !== 4'd0) begin
            bad++;
            $display("FAIL three_boxes: caixas=%0d esteira=%b cont=%0d want %0d 1 0",
                     bus.caixas, bus.esteira, bus.contagem, exp_caixas(3));
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 12; i++) pulse_item();
        ticks(4);
        ticks(999);
        total++;
        if (bus.erro !== 1'b0 || bus.troca_req !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: erro=%b req=%b want 0 1", bus.erro, bus.troca_req);
        end
        tick();
        total++;
        if (bus.erro !== 1'b1 || bus.esteira !== 1'b0 || bus.troca_req !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fault: erro=%b esteira=%b req=%b want 1 0 0", bus.erro, bus.esteira, bus.troca_req);
        end
        bus.troca_ack = 1'b1;
        ticks(5);
        bus.troca_ack = 1'b0;
        ticks(5);
        total++;
        if (bus.erro !== 1'b1 || bus.esteira !== 1'b0 || bus.contagem !== 4'd12) begin
            bad++;
            $display("FAIL fault_sticky: erro=%b esteira=%b cont=%0d want 1 0 12", bus.erro, bus.esteira, bus.contagem);
        end
    endtask

    task automatic test_reset_troca();
        bus.habilita = 1'b0;
        test_reset();
        bus.habilita = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) pulse_item();
        ticks(4);
        total++;
        if (bus.troca_req !== 1'b1) begin
            bad++;
            $display("FAIL reach_troca: req=%b want 1", bus.troca_req);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bus.troca_req !== 1'b0 || bus.contagem !== 4'd0 || bus.esteira !== 1'b0 || bus.erro !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: req=%b cont=%0d esteira=%b erro=%b want 0 0 0 0",
                     bus.troca_req, bus.contagem, bus.esteira, bus.erro);
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        bus.habilita    = 1'b0;
        bus.sensor_item = 1'b0;
        bus.troca_ack   = 1'b0;
        test_reset();
        test_contagem();
        test_perdido();
        test_troca();
        test_desabilita();
        test_back_to_back();
        test_timeout();
        test_reset_troca();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/controlador_embalagem.md
# controlador_embalagem

Packaging controller that sequences the dozen counter in the item-sorting line: counts items from a conveyor sensor, stops the belt when a box holds 12 items, handshakes a box change with the handler mechanism, clears the count and restarts the belt. Sits between the raw sensor/actuator pins and the 7-segment display logic, which reads `contagem`.

## Interface
- `PARADA_CICLOS`, default 4: cycles the belt stays stopped before the box-change request (1..255).
- `TIMEOUT_CICLOS`, default 1000: maximum cycles waiting for `troca_ack` before fault (1..65535).

- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `habilita`  in  1  run enable from operator panel; synchronous to `clock`.
- `sensor_item`  in  1  raw item sensor, asynchronous; one item per rising edge.
- `troca_ack`  in  1  box-change acknowledge from handler; synchronous to `clock`.
- `esteira`  out  1  belt motor run command.
- `troca_req`  out  1  box-change request.
- `contagem`  out  4  items in current box, 0..12.
- `caixa_cheia`  out  1  one-cycle pulse per completed box.
- `perdido`  out  1  one-cycle pulse: item edge detected while not counting.
- `erro`  out  1  sticky fault: handler timeout.
- `caixas`  out  8  completed-box count (see Configuration).

## Operation
- Reset: state IDLE; all outputs 0; `contagem`=0; synchronizer, timers, `caixas` = 0.
- `sensor_item`: 2-FF synchronizer plus a third register; item pulse = stage2 & ~stage3.
- States: IDLE, CONTANDO, PARADA, TROCA, LIBERA, ERRO. All outputs registered.
- IDLE: `esteira`=0. `habilita`=1 -> CONTANDO.
- CONTANDO: `esteira`=1. Item pulse increments `contagem`. Increment to 12 -> PARADA on the same edge (`esteira` 0 from that edge). `habilita`=0 -> IDLE, `contagem` retained; an item pulse on that same cycle is still counted.
- PARADA: `esteira`=0; timer counts PARADA_CICLOS cycles, then -> TROCA.
- TROCA: `troca_req`=1, timeout timer runs. `troca_ack`=1 -> LIBERA, `contagem`<=0, `troca_req`<=0, `caixa_cheia` pulses, `caixas` increments. Timer reaching TIMEOUT_CICLOS without ack -> ERRO. Ack and expiry on same cycle: ack wins.
- LIBERA: waits `troca_ack`=0; then -> CONTANDO if `habilita`=1, else IDLE.
- ERRO: `esteira`=0, `troca_req`=0, `erro`=1; exit only via `reset`.
- Item pulse in any state other than CONTANDO: not counted, `perdido` pulses one cycle.
- `habilita` ignored outside IDLE/CONTANDO. `contagem` never exceeds 12.

## Timing
- `sensor_item` rise to `contagem` update: 3rd rising `clock` edge after the input is sampled high.
- Count reaching 12 to `esteira`=0: same edge.
- `esteira` falling to `troca_req` rising: PARADA_CICLOS edges.
- `troca_ack` high to `troca_req` low, `contagem`=0, `caixa_cheia`=1: 1 edge.
- `troca_ack` low to `esteira`=1 (with `habilita`): 1 edge.
- Sensor pulses shorter than one `clock` period may be missed; input highs of at least 2 periods are guaranteed detected.
- `reset` asserted mid-operation: outputs clear immediately, independent of `clock`; handler sees `troca_req` drop.

## Configuration
- `CONTA_CAIXAS_EN` defined: `caixas` counts completed boxes, wraps 255 -> 0, cleared only by `reset`.
- Not defined: counter not built; `caixas` tied to 0. Port list identical in both builds.

## Test plan
- Reset then `habilita`=1, 12 sensor pulses -> `contagem` 1..12, `esteira`=0 on the 12th update, `troca_req`=1 after 4 further cycles.
- In TROCA, raise `troca_ack` -> next edge `contagem`=0, `caixa_cheia` pulse, `caixas`=1; drop ack -> `esteira`=1.
- Withhold `troca_ack` for 1000 cycles -> `erro`=1, `esteira`=0, `troca_req`=0; hold until `reset`.
- Sensor pulse during PARADA -> `perdido` one-cycle pulse, `contagem` stays 12.
- `habilita`=0 at `contagem`=5 -> IDLE, `esteira`=0, `contagem`=5; re-enable and 7 pulses -> 12, PARADA.
- `reset` asserted in TROCA -> all outputs 0 immediately; with `CONTA_CAIXAS_EN` off, `caixas` stays 0 after 3 boxes.
